// File: rtl/stage_sequencer.sv
// ============================================================================
// Module  : stage_sequencer
// Purpose : Multicycle CPU controller: boot/load/run/halt mode FSM plus a
//           latency/ready-gated stage walker that owns the PC and retire pulse.
//           Optional PERF_CNT_EN adds RUN-cycle and retire counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_sequencer #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned LAT_W      = 4,
  parameter logic [NUM_STAGES*LAT_W-1:0] STAGE_LAT = 20'h1_1_5_0_0,
  parameter int unsigned PC_STAGE   = 3,
  parameter int unsigned PC_W       = 32,
  parameter logic [7:0]  BOOT_BYTE  = 8'hAA,
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  load_done,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  stop_req,
  input  logic [PC_W-1:0]       next_pc,
  output logic [1:0]            mode,
  output logic [SW-1:0]         stage_idx,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic [NUM_STAGES-1:0] stage_adv,
  output logic [PC_W-1:0]       pc,
  output logic                  retire,
  output logic                  halted,
  output logic [7:0]            led,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           retire_cnt
);

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_RUN  = 2'd2;
  localparam logic [1:0] MODE_HALT = 2'd3;

  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] cur_lat;
  logic [LAT_W-1:0] lat_tab [NUM_STAGES];
  logic             lat_done;
  logic             adv;
  logic             last_stage;
  logic             boot;
  logic             load_start;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_lat_tab
    assign lat_tab[g] = STAGE_LAT[g*LAT_W +: LAT_W];
  end

  assign cur_lat    = lat_tab[stage_idx];
  assign lat_done   = (lat == cur_lat);
  assign adv        = (mode == MODE_RUN) && lat_done && stage_ready[stage_idx];
  assign last_stage = (stage_idx == SW'(NUM_STAGES - 1));
  assign boot       = rx_valid && (rx_data == BOOT_BYTE);
  assign load_start = boot && ((mode == MODE_IDLE) || (mode == MODE_HALT));

  always_comb begin
    stage_adv    = '0;
    stage_onehot = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_idx == SW'(i)) begin
        stage_adv[i]    = adv;
        stage_onehot[i] = (mode == MODE_RUN);
      end
    end
  end

  assign retire = stage_adv[NUM_STAGES-1];
  assign halted = (mode == MODE_HALT);
  assign led    = pc[7:0] | {2'b00, mode, 4'b0000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode      <= MODE_IDLE;
      stage_idx <= '0;
      lat       <= '0;
      pc        <= '0;
    end else begin
      case (mode)
        MODE_IDLE: begin
          if (boot) mode <= MODE_LOAD;
        end
        MODE_LOAD: begin
          if (load_done) begin
            mode      <= MODE_RUN;
            stage_idx <= '0;
            lat       <= '0;
          end
        end
        MODE_RUN: begin
          if (adv) begin
            lat <= '0;
            if (stage_idx == SW'(PC_STAGE)) pc <= next_pc;
            if (last_stage) begin
              if (stop_req) mode <= MODE_HALT;
              else          stage_idx <= '0;
            end else begin
              stage_idx <= stage_idx + SW'(1);
            end
          end else if (!lat_done) begin
            // Saturate at the stage latency so a stalled stage stays ready to fire.
            lat <= lat + LAT_W'(1);
          end
        end
        default: begin
          if (boot) begin
            mode      <= MODE_LOAD;
            pc        <= '0;
            stage_idx <= '0;
            lat       <= '0;
          end
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] retire_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else if (load_start) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else if (mode == MODE_RUN) begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`else
  logic unused_perf;
  assign unused_perf = load_start;
  assign cycle_cnt   = '0;
  assign retire_cnt  = '0;
`endif

endmodule

`default_nettype wire
